// File: rtl/window_gate_pkg.sv
// window_gate_pkg: shared types and defaults for the multi-channel window gate.
// Optional feature macro used by this slice: WINDOW_GATE_HOLDOFF_EN.
package window_gate_pkg;

  // Default channel count and counter width.
  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 32;

  // Per-channel retrigger policy. Reserved codes behave like IGNORE.
  typedef enum logic [1:0] {
    RM_IGNORE  = 2'd0,
    RM_RESTART = 2'd1,
    RM_RSVD2   = 2'd2,
    RM_RSVD3   = 2'd3
  } retrig_mode_e;

  // Channel FSM states. ST_HOLD is only reachable when the holdoff feature is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // True only for the RESTART code, so reserved codes fall back to IGNORE.
  function automatic logic is_restart(input retrig_mode_e mode);
    return (mode == RM_RESTART);
  endfunction

endpackage

// File: rtl/window_gate_if.sv
// window_gate_if: per-channel request/config/status bundle between the trigger
// distribution logic (master) and the window gate (slave).
// holdoff_cnt exists only when WINDOW_GATE_HOLDOFF_EN is defined.
interface window_gate_if
  import window_gate_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [NCH-1:0]       start;
  logic [NCH*CNT_W-1:0] delay_cnt;
  logic [NCH*CNT_W-1:0] total_cnt;
  logic [NCH*2-1:0]     retrig_mode;
  logic [NCH-1:0]       clr_ovr;
`ifdef WINDOW_GATE_HOLDOFF_EN
  logic [CNT_W-1:0]     holdoff_cnt;
`endif
  logic [NCH-1:0]       active;
  logic [NCH-1:0]       valid;
  logic [NCH-1:0]       first;
  logic [NCH-1:0]       last;
  logic [NCH-1:0]       overrun;

  // Trigger side: drives requests and configuration, observes window status.
  modport master (
    output start, delay_cnt, total_cnt, retrig_mode, clr_ovr,
`ifdef WINDOW_GATE_HOLDOFF_EN
    output holdoff_cnt,
`endif
    input  active, valid, first, last, overrun
  );

  // Gate side: consumes requests and configuration, produces window status.
  modport slave (
    input  start, delay_cnt, total_cnt, retrig_mode, clr_ovr,
`ifdef WINDOW_GATE_HOLDOFF_EN
    input  holdoff_cnt,
`endif
    output active, valid, first, last, overrun
  );

endinterface

// File: rtl/window_gate_chan.sv
// window_gate_chan: one channel of the window gate. IDLE/RUN(/HOLD) FSM with a
// window index counter, per-window latched configuration and a sticky overrun flag.
// With WINDOW_GATE_HOLDOFF_EN a post-window dead time of holdoff_cnt cycles is added.
module window_gate_chan
  import window_gate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] delay_cnt,
  input  logic [CNT_W-1:0] total_cnt,
  input  logic [1:0]       retrig_mode,
  input  logic             clr_ovr,
`ifdef WINDOW_GATE_HOLDOFF_EN
  input  logic [CNT_W-1:0] holdoff_cnt,
`endif
  output logic             active,
  output logic             valid,
  output logic             first,
  output logic             last,
  output logic             overrun
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] k_reg, k_next;
  logic [CNT_W-1:0] delay_reg, delay_next;
  logic [CNT_W-1:0] total_reg, total_next;
  retrig_mode_e     mode_reg, mode_next;
`ifdef WINDOW_GATE_HOLDOFF_EN
  logic [CNT_W-1:0] hold_k_reg, hold_k_next;
  logic [CNT_W-1:0] hold_len_reg, hold_len_next;
`endif

  logic active_reg, valid_reg, first_reg, last_reg, overrun_reg;
  logic active_next, valid_next, first_next, last_next, overrun_next;

  logic at_last;   // current RUN cycle is index total-1
  logic gap_req;   // a completed window must be followed by dead time
  logic start_ok;  // start that can open a window (non-zero length)
  logic start_bad; // start that asks for a zero-length window
  logic accept;    // open a fresh window next cycle
  logic ovr_set;   // this cycle's start is dropped or rejected
  logic run_next;

  assign at_last   = (k_reg == total_reg - CNT_W'(1));
  assign start_ok  = start && (total_cnt != '0);
  assign start_bad = start && (total_cnt == '0);
`ifdef WINDOW_GATE_HOLDOFF_EN
  assign gap_req   = (holdoff_cnt != '0);
`else
  assign gap_req   = 1'b0;
`endif

  // State register, counters, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      delay_reg    <= '0;
      total_reg    <= '0;
      mode_reg     <= RM_IGNORE;
`ifdef WINDOW_GATE_HOLDOFF_EN
      hold_k_reg   <= '0;
      hold_len_reg <= '0;
`endif
      active_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      delay_reg    <= delay_next;
      total_reg    <= total_next;
      mode_reg     <= mode_next;
`ifdef WINDOW_GATE_HOLDOFF_EN
      hold_k_reg   <= hold_k_next;
      hold_len_reg <= hold_len_next;
`endif
      active_reg   <= active_next;
      valid_reg    <= valid_next;
      first_reg    <= first_next;
      last_reg     <= last_next;
      overrun_reg  <= overrun_next;
    end
  end

  // Next-state logic: window acceptance, retrigger policy, holdoff and overrun detection.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    delay_next = delay_reg;
    total_next = total_reg;
    mode_next  = mode_reg;
`ifdef WINDOW_GATE_HOLDOFF_EN
    hold_k_next   = hold_k_reg;
    hold_len_next = hold_len_reg;
`endif
    accept  = 1'b0;
    ovr_set = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          accept = 1'b1;
        end else if (start_bad) begin
          ovr_set = 1'b1;
        end
      end

      ST_RUN: begin
        if (at_last && gap_req) begin
          // Dead time wins over a back-to-back request; that start is rejected.
          state_next = ST_HOLD;
          ovr_set    = start;
`ifdef WINDOW_GATE_HOLDOFF_EN
          hold_k_next   = '0;
          hold_len_next = holdoff_cnt;
`endif
        end else if (at_last) begin
          if (start_ok) begin
            accept = 1'b1;
          end else begin
            state_next = ST_IDLE;
            ovr_set    = start_bad;
          end
        end else begin
          k_next = k_reg + CNT_W'(1);
          if (start) begin
            if (is_restart(mode_reg) && start_ok) begin
              accept = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
`ifdef WINDOW_GATE_HOLDOFF_EN
        // The final hold cycle doubles as the acceptance point, so a held start
        // sees exactly holdoff_cnt inactive cycles between windows.
        if (hold_k_reg == hold_len_reg - CNT_W'(1)) begin
          if (start_ok) begin
            accept = 1'b1;
          end else begin
            state_next = ST_IDLE;
            ovr_set    = start_bad;
          end
        end else begin
          hold_k_next = hold_k_reg + CNT_W'(1);
          ovr_set     = start;
        end
`else
        state_next = ST_IDLE;
`endif
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A new window restarts the index and captures the request's configuration.
    if (accept) begin
      state_next = ST_RUN;
      k_next     = '0;
      delay_next = delay_cnt;
      total_next = total_cnt;
      mode_next  = retrig_mode_e'(retrig_mode);
    end
  end

  // Output decode from next state so every output is a plain flop.
  always_comb begin
    run_next     = (state_next == ST_RUN);
    active_next  = run_next;
    first_next   = run_next && (k_next == '0);
    valid_next   = run_next && (k_next >= delay_next);
    last_next    = run_next && (k_next == total_next - CNT_W'(1));
    overrun_next = ovr_set || (overrun_reg && !clr_ovr);
  end

  assign active  = active_reg;
  assign valid   = valid_reg;
  assign first   = first_reg;
  assign last    = last_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/window_gate.sv
// window_gate: NCH independent trigger-gated window generators. Slices the packed
// per-channel buses of window_gate_if and instantiates one window_gate_chan per channel.
// Build with WINDOW_GATE_HOLDOFF_EN to enable the shared post-window holdoff.
module window_gate
  import window_gate_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  window_gate_if.slave  bus
);

  logic [NCH-1:0] active_w;
  logic [NCH-1:0] valid_w;
  logic [NCH-1:0] first_w;
  logic [NCH-1:0] last_w;
  logic [NCH-1:0] overrun_w;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      window_gate_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .start       (bus.start[gi]),
        .delay_cnt   (bus.delay_cnt[gi*CNT_W +: CNT_W]),
        .total_cnt   (bus.total_cnt[gi*CNT_W +: CNT_W]),
        .retrig_mode (bus.retrig_mode[gi*2 +: 2]),
        .clr_ovr     (bus.clr_ovr[gi]),
`ifdef WINDOW_GATE_HOLDOFF_EN
        .holdoff_cnt (bus.holdoff_cnt),
`endif
        .active      (active_w[gi]),
        .valid       (valid_w[gi]),
        .first       (first_w[gi]),
        .last        (last_w[gi]),
        .overrun     (overrun_w[gi])
      );
    end
  endgenerate

  assign bus.active  = active_w;
  assign bus.valid   = valid_w;
  assign bus.first   = first_w;
  assign bus.last    = last_w;
  assign bus.overrun = overrun_w;

endmodule
